// File: rtl/i2c_slave_responder.sv
// I2C target at a fixed 7-bit address. It ACKs its address, receives write bytes,
// and serves read bytes from the user side. SDA is driven open-drain and SCL is never stretched.
module i2c_slave_responder #(
    parameter logic [6:0] ADDR = 7'b1001000,
    parameter int         SYNC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       busy,
    output logic       nack_rx
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
    } state_t;

    logic [SYNC-1:0] scl_sync_q, sda_sync_q;
    logic            scl_prev_q, sda_prev_q;
    logic            scl_s, sda_s;
    logic            scl_rise, scl_fall, start_det, stop_det;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [7:0]      shift_q;
    logic            rw_q;
    logic            ph_q;
    logic            fall_q;
    logic            sda_oe_q;
    logic            busy_q;
    logic [7:0]      wr_data_q;
    logic            wr_valid_q;
    logic            rd_req_q;
    logic            nack_q;

    assign scl_s     = scl_sync_q[SYNC-1];
    assign sda_s     = sda_sync_q[SYNC-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA edge next to an SCL edge is not a START/STOP.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC-2:0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // fall_q delays SDA changes to the cycle after the detected SCL fall. rd_req fires on
    // the fall itself, so rd_data is sampled while rd_req is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ph_q       <= 1'b0;
            fall_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_data_q  <= 8'h00;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            nack_q     <= 1'b0;
            fall_q     <= scl_fall;
            if (start_det) begin
                state_q  <= S_ADDR;
                cnt_q    <= 3'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                cnt_q    <= 3'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                rw_q <= sda_s;
                                ph_q <= 1'b0;
                                if (shift_q[6:0] == ADDR) begin
                                    state_q <= S_ADDR_ACK;
                                    busy_q  <= 1'b1;
                                end else begin
                                    state_q <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK, S_WR_ACK: begin
                        if (scl_fall && ph_q && rw_q) rd_req_q <= 1'b1;
                        if (fall_q) begin
                            if (!ph_q) begin
                                sda_oe_q <= 1'b1;
                                ph_q     <= 1'b1;
                            end else if (rw_q) begin
                                shift_q  <= rd_data;
                                sda_oe_q <= ~rd_data[7];
                                cnt_q    <= 3'd0;
                                ph_q     <= 1'b0;
                                state_q  <= S_RD_DATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                cnt_q    <= 3'd0;
                                state_q  <= S_WR_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                wr_data_q  <= {shift_q[6:0], sda_s};
                                wr_valid_q <= 1'b1;
                                ph_q       <= 1'b0;
                                state_q    <= S_WR_ACK;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (fall_q) begin
                            if (cnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                cnt_q    <= 3'd0;
                                ph_q     <= 1'b0;
                                state_q  <= S_RD_ACK;
                            end else begin
                                sda_oe_q <= ~shift_q[6];
                                shift_q  <= {shift_q[6:0], 1'b0};
                                cnt_q    <= cnt_q + 3'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        // ph_q records that the master ACKed, so the next fall reloads a byte.
                        if (scl_rise) begin
                            if (sda_s) begin
                                nack_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IGNORE;
                            end else begin
                                ph_q <= 1'b1;
                            end
                        end
                        if (scl_fall && ph_q) rd_req_q <= 1'b1;
                        if (fall_q && ph_q) begin
                            shift_q  <= rd_data;
                            sda_oe_q <= ~rd_data[7];
                            cnt_q    <= 3'd0;
                            ph_q     <= 1'b0;
                            state_q  <= S_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rd_req   = rd_req_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign busy     = busy_q;
    assign nack_rx  = nack_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master drives table and random
// transactions, and the results are checked against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] rd_data;
    logic       rd_req, wr_valid, busy, nack_rx;
    logic [7:0] wr_data;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_responder #(.ADDR(7'h48), .SYNC(2)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .rd_data(rd_data), .rd_req(rd_req), .wr_data(wr_data),
        .wr_valid(wr_valid), .busy(busy), .nack_rx(nack_rx)
    );

    typedef struct {
        logic [6:0]      addr;
        logic            rw;
        int              n;
        logic [3:0][7:0] d;
        logic            exp_ack;
        int              exp_wr;
        int              exp_rdreq;
        int              exp_nack;
    } vec_t;

    int total = 0;
    int bad = 0;

    logic [7:0] rd_bytes[256];
    logic [7:0] wr_log[256];
    int rd_idx = 0, rdreq_cnt = 0, wr_cnt = 0, nack_cnt = 0;
    bit rq_prev = 1'b0;

    // The user side advances to the next read byte only after the rd_req cycle has passed.
    always @(negedge clk) begin
        if (rq_prev) rd_idx = rd_idx + 1;
        rq_prev = rd_req;
        if (rd_req) rdreq_cnt = rdreq_cnt + 1;
        if (wr_valid) begin
            wr_log[wr_cnt[7:0]] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (nack_rx) nack_cnt = nack_cnt + 1;
    end
    assign rd_data = rd_bytes[rd_idx[7:0]];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input bit b, output bit s);
        m_low = ~b; wq();
        scl = 1'b1; wq();
        s = sda; wq();
        scl = 1'b0; wq();
    endtask

    task automatic start_c();
        m_low = 1'b0; wq();
        scl = 1'b1; wq();
        m_low = 1'b1; wq();
        scl = 1'b0; wq();
    endtask

    task automatic stop_c();
        m_low = 1'b1; wq();
        scl = 1'b1; wq();
        m_low = 1'b0; wq();
    endtask

    task automatic byte_wr(input logic [7:0] d, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic byte_rd(input bit last, output logic [7:0] d);
        bit s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        bit_xfer(last, s);
    endtask

    function automatic vec_t model(input logic [6:0] a, input logic rw, input int n,
                                   input logic [31:0] d);
        vec_t v;
        v.addr = a; v.rw = rw; v.n = n; v.d = d;
        v.exp_ack   = (a == 7'h48);
        v.exp_wr    = (v.exp_ack && !rw) ? n : 0;
        v.exp_rdreq = (v.exp_ack && rw) ? n : 0;
        v.exp_nack  = (v.exp_ack && rw) ? 1 : 0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int wr0, rq0, nk0;
        bit ack;
        logic [7:0] got;
        wr0 = wr_cnt; rq0 = rdreq_cnt; nk0 = nack_cnt;
        for (int k = 0; k < v.n; k++) rd_bytes[8'(rd_idx + k)] = v.d[k];
        start_c();
        byte_wr({v.addr, v.rw}, ack);
        check("addr_ack", int'(ack), int'(v.exp_ack));
        check("busy_after_addr", int'(busy), int'(v.exp_ack));
        if (v.exp_ack && v.rw) begin
            for (int k = 0; k < v.n; k++) begin
                byte_rd(k == v.n - 1, got);
                check("rd_byte", int'(got), int'(v.d[k]));
            end
        end else if (v.exp_ack) begin
            for (int k = 0; k < v.n; k++) begin
                byte_wr(v.d[k], ack);
                check("wr_byte_ack", int'(ack), 1);
            end
        end else begin
            byte_wr(v.d[0], ack);
            check("ignored_byte_ack", int'(ack), 0);
        end
        stop_c();
        wq();
        check("busy_after_stop", int'(busy), 0);
        check("sda_released", int'(sda), 1);
        check("wr_valid_count", wr_cnt - wr0, v.exp_wr);
        check("rd_req_count", rdreq_cnt - rq0, v.exp_rdreq);
        check("nack_rx_count", nack_cnt - nk0, v.exp_nack);
        for (int k = 0; k < v.exp_wr; k++)
            check("wr_data", int'(wr_log[8'(wr0 + k)]), int'(v.d[k]));
    endtask

    vec_t tbl[6];

    initial begin
        bit ack, s;
        logic [7:0] got;
        int wr0, rq0, nk0;

        tbl[0] = '{addr:7'h48, rw:1'b0, n:2, d:{8'h00, 8'h00, 8'h3C, 8'hA5},
                   exp_ack:1'b1, exp_wr:2, exp_rdreq:0, exp_nack:0};
        tbl[1] = '{addr:7'h49, rw:1'b0, n:1, d:{8'h00, 8'h00, 8'h00, 8'h55},
                   exp_ack:1'b0, exp_wr:0, exp_rdreq:0, exp_nack:0};
        tbl[2] = '{addr:7'h48, rw:1'b1, n:2, d:{8'h00, 8'h00, 8'h7E, 8'h81},
                   exp_ack:1'b1, exp_wr:0, exp_rdreq:2, exp_nack:1};
        tbl[3] = '{addr:7'h48, rw:1'b0, n:3, d:{8'h00, 8'h80, 8'hFF, 8'h00},
                   exp_ack:1'b1, exp_wr:3, exp_rdreq:0, exp_nack:0};
        tbl[4] = '{addr:7'h08, rw:1'b1, n:1, d:{8'h00, 8'h00, 8'h00, 8'hAA},
                   exp_ack:1'b0, exp_wr:0, exp_rdreq:0, exp_nack:0};
        tbl[5] = '{addr:7'h48, rw:1'b1, n:1, d:{8'h00, 8'h00, 8'h00, 8'h00},
                   exp_ack:1'b1, exp_wr:0, exp_rdreq:1, exp_nack:1};

        repeat (4) @(negedge clk);
        check("reset_sda", int'(sda), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_data", int'(wr_data), 0);
        check("reset_wr_valid", int'(wr_valid), 0);
        check("reset_rd_req", int'(rd_req), 0);
        check("reset_nack_rx", int'(nack_rx), 0);
        reset = 1'b0;
        wq();

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Write one byte, then a repeated START into a one-byte read with no STOP between them.
        wr0 = wr_cnt; rq0 = rdreq_cnt; nk0 = nack_cnt;
        rd_bytes[8'(rd_idx)] = 8'hF0;
        start_c();
        byte_wr({7'h48, 1'b0}, ack);
        check("rs_addr_w_ack", int'(ack), 1);
        byte_wr(8'h11, ack);
        check("rs_wr_ack", int'(ack), 1);
        start_c();
        byte_wr({7'h48, 1'b1}, ack);
        check("rs_addr_r_ack", int'(ack), 1);
        byte_rd(1'b1, got);
        check("rs_rd_byte", int'(got), 8'hF0);
        stop_c();
        wq();
        check("rs_wr_count", wr_cnt - wr0, 1);
        check("rs_wr_data", int'(wr_log[8'(wr0)]), 8'h11);
        check("rs_rd_req_count", rdreq_cnt - rq0, 1);
        check("rs_nack_count", nack_cnt - nk0, 1);

        // A STOP in the middle of a byte discards the partial byte.
        wr0 = wr_cnt;
        start_c();
        byte_wr({7'h48, 1'b0}, ack);
        check("part_addr_ack", int'(ack), 1);
        for (int i = 0; i < 4; i++) bit_xfer(i[0], s);
        stop_c();
        wq();
        check("part_wr_count", wr_cnt - wr0, 0);
        check("part_busy", int'(busy), 0);
        run_vec(tbl[0]);

        // Reset while the target is driving a 0 data bit onto SDA.
        rd_bytes[8'(rd_idx)] = 8'h00;
        start_c();
        byte_wr({7'h48, 1'b1}, ack);
        check("rst_addr_ack", int'(ack), 1);
        check("rst_sda_driven_low", int'(sda), 0);
        check("rst_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_sda_released", int'(sda), 1);
        check("rst_busy_cleared", int'(busy), 0);
        reset = 1'b0;
        wq();
        stop_c();
        wq();
        run_vec(tbl[2]);

        for (int i = 0; i < 20; i++) begin
            logic [6:0] a;
            vec_t v;
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h48;
            v = model(a, 1'($urandom), $urandom_range(1, 4), $urandom);
            run_vec(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
